mixcolumns_serial: RTL
======================

Name: mixcolumns_serial

Overview:
- Byte-serial AES MixColumns stage. Sits directly downstream of the byte-serial ShiftRows stage and consumes its output byte stream.
- Gathers each 4-byte state column, applies the GF(2^8) column transform, and re-emits the column one byte per cycle.
- Also provides the final-round bypass (no MixColumns) with identical latency, so the round datapath keeps fixed timing.

Parameters:
- INVERSE, 0: 0 = MixColumns (coeffs 02 03 01 01); 1 = InvMixColumns (coeffs 0e 0b 0d 09).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inbyte  input  8  state byte from ShiftRows, column-major order, row 0 first.
- in_valid  input  1  inbyte is valid this cycle; driven from the ShiftRows ready.
- last_round  input  1  1 = bypass the transform for this column; sampled with the column's byte 3.
- outbyte  output  8  transformed byte, row 0 first; registered.
- ready  output  1  outbyte valid this cycle; registered.

Behaviour:
- Reset (clock edge with reset=1):
  - outbyte=8'h00 and ready=0 from the next cycle.
  - Byte counter cleared to 0; any partially gathered column is discarded.
  - Emission is aborted, including mid-emission.
  - reset has priority over in_valid.
- Input capture:
  - 2-bit in_cnt, wraps 3->0. Advances only on edges with in_valid=1.
  - Byte written to capture register a[in_cnt].
  - in_valid=0 holds in_cnt and the capture registers; gaps of any length are allowed.
- Column completion (edge with in_valid=1, in_cnt=3):
  - Result computed combinationally from a0..a2 plus the current inbyte.
  - Result loaded into a 4-byte output holding register b0..b3.
  - last_round is sampled on this same edge; if 1, b = a (pass-through).
- Transform, forward (INVERSE=0):
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- Transform, inverse (INVERSE=1):
  - Coefficient rows {0e,0b,0d,09}, rotated right by one per output row.
- Arithmetic:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Higher multiples are built from xtime chains and XOR. All 8-bit, no carries.
- Output FSM states:
  - IDLE: ready=0, outbyte holds its last value.
  - EMIT with 2-bit out_idx.
- Output FSM transitions:
  - Column completion at edge T: EMIT, out_idx=0, so outbyte=b0 and ready=1 during cycle T+1.
  - Cycles T+1..T+4 present b0, b1, b2, b3.
  - After b3: return to IDLE unless another column completed on that same edge.
  - Latency from the byte-3 accept edge to b0 is exactly 1 cycle.
- Simultaneous events:
  - Next column's byte 3 accepted on the edge that retires b3: reload b, out_idx=0, ready stays 1, no bubble.
  - A column can never complete while out_idx<3, because it needs 4 accepts. No overflow or back-pressure; the block has no stall input.
- Throughput: 1 byte/cycle sustained; 16 bytes per AES state.

Test Plan:
- Forward, single column: in_valid pulses db,13,53,45 on consecutive cycles -> ready=1 for 4 cycles starting 1 cycle after byte 45; outbyte 8e,4d,a1,bc; ready=0 afterwards.
- Streaming: 4 columns back-to-back (d4 bf 5d 30 | e0 b4 52 ae | b8 41 11 f1 | 1e 27 98 e5) -> 16 contiguous ready cycles; outputs 04 66 81 e5 | e0 cb 19 9a | 48 f8 d3 7a | 28 06 26 4c.
- Gapped input: column f2,0a,22,5c with 3 idle cycles between each byte -> no ready until 1 cycle after byte 5c; then 9f,dc,58,9d.
- Bypass: last_round=1 with byte 3 of column c6,01,d4,2d -> outbyte c6,01,d4,2d with the same 1-cycle latency; the next column with last_round=0 is transformed normally.
- Reset: reset after 2 bytes of a column, and separately during the 2nd emitted byte -> ready=0 the next cycle; a fresh column db,13,53,45 then yields 8e,4d,a1,bc, with no residue from the aborted data.
- INVERSE=1 build: input 8e,4d,a1,bc -> db,13,53,45; input 01,01,01,01 -> 01,01,01,01.

Source files
------------

// File: rtl/mixcolumns_serial.sv
// mixcolumns_serial
// Byte-serial AES MixColumns / InvMixColumns stage with a final-round bypass.
// It collects four state bytes (row 0 first) into one column and transforms the
// column as byte 3 arrives. It then sends the result out one byte per cycle. The
// first output byte comes exactly one cycle after byte 3 is accepted.
//
// Parameters:
//   INVERSE    : 0 = MixColumns (02 03 01 01), 1 = InvMixColumns (0e 0b 0d 09)
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   inbyte     : state byte from ShiftRows, column-major, row 0 first
//   in_valid   : inbyte is valid this cycle
//   last_round : 1 = pass the column through untransformed (sampled with byte 3)
//   outbyte    : transformed byte, row 0 first (registered)
//   ready      : outbyte valid this cycle (registered)
module mixcolumns_serial #(
    parameter bit INVERSE = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] inbyte,
    input  logic       in_valid,
    input  logic       last_round,
    output logic [7:0] outbyte,
    output logic       ready
);

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned CAP_ROWS = NUM_ROWS - 1;

    // Coefficients of the first matrix row. Row i uses this row rotated right by i.
    localparam logic [3:0] COEF0 = INVERSE ? 4'he : 4'h2;
    localparam logic [3:0] COEF1 = INVERSE ? 4'hb : 4'h3;
    localparam logic [3:0] COEF2 = INVERSE ? 4'hd : 4'h1;
    localparam logic [3:0] COEF3 = INVERSE ? 4'h9 : 4'h1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // GF(2^8) doubling, reduced modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        xtime = {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant: XOR of the selected x, 2x, 4x, 8x terms.
    function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] x,
                                               input logic [3:0]        c);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        x2   = xtime(x);
        x4   = xtime(x2);
        x8   = xtime(x4);
        gmul = (c[0] ? x  : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^
               (c[3] ? x8 : 8'h00);
    endfunction

    // Coefficient at rotation offset k = (col - row) mod 4.
    function automatic logic [3:0] coef(input logic [1:0] k);
        case (k)
            2'd0:    coef = COEF0;
            2'd1:    coef = COEF1;
            2'd2:    coef = COEF2;
            default: coef = COEF3;
        endcase
    endfunction

    // Registered state.
    state_e            state_q,   state_d;
    logic [1:0]        in_cnt_q,  in_cnt_d;
    logic [1:0]        out_idx_q, out_idx_d;
    logic [BYTE_W-1:0] a_q [CAP_ROWS];
    logic [BYTE_W-1:0] a_d [CAP_ROWS];
    logic [BYTE_W-1:0] b_q [NUM_ROWS];
    logic [BYTE_W-1:0] b_d [NUM_ROWS];
    logic [BYTE_W-1:0] outbyte_q, outbyte_d;
    logic              ready_q,   ready_d;

    // Combinational column result.
    logic              col_done_c;
    logic [BYTE_W-1:0] col_c [NUM_ROWS];
    logic [BYTE_W-1:0] mix_c [NUM_ROWS];
    logic [BYTE_W-1:0] res_c [NUM_ROWS];

    assign col_done_c = in_valid && (in_cnt_q == 2'd3);

    // Current column: three captured bytes plus the byte arriving now.
    always_comb begin
        for (int j = 0; j < int'(CAP_ROWS); j++) begin
            col_c[j] = a_q[j];
        end
        col_c[CAP_ROWS] = inbyte;
    end

    // Column transform: mix[i] = XOR over j of coef((j - i) mod 4) * col[j].
    always_comb begin
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            mix_c[i] = '0;
            for (int j = 0; j < int'(NUM_ROWS); j++) begin
                mix_c[i] = mix_c[i] ^ gmul(col_c[j], coef(2'(j - i)));
            end
        end
    end

    // Final-round bypass selects the raw column.
    always_comb begin
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            res_c[i] = last_round ? col_c[i] : mix_c[i];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_idx_q <= '0;
            outbyte_q <= '0;
            ready_q   <= 1'b0;
            for (int j = 0; j < int'(CAP_ROWS); j++) begin
                a_q[j] <= '0;
            end
            for (int i = 0; i < int'(NUM_ROWS); i++) begin
                b_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_idx_q <= out_idx_d;
            outbyte_q <= outbyte_d;
            ready_q   <= ready_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    // Next-state logic for capture and emission.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_idx_d = out_idx_q;
        outbyte_d = outbyte_q;
        ready_d   = 1'b0;
        a_d       = a_q;
        b_d       = b_q;

        // Capture: byte 3 is not stored; it feeds the transform directly.
        if (in_valid) begin
            in_cnt_d = 2'(in_cnt_q + 2'd1);
            case (in_cnt_q)
                2'd0:    a_d[0] = inbyte;
                2'd1:    a_d[1] = inbyte;
                2'd2:    a_d[2] = inbyte;
                default: ;
            endcase
        end

        // A new column restarts emission at b0. This can only happen when the
        // previous column is idle or on its last byte, so there is no bubble.
        if (col_done_c) begin
            state_d   = EMIT;
            out_idx_d = '0;
            b_d       = res_c;
            outbyte_d = res_c[0];
            ready_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_d = 1'b0;
                end
                EMIT: begin
                    if (out_idx_q == 2'd3) begin
                        state_d = IDLE;
                        ready_d = 1'b0;
                    end else begin
                        out_idx_d = 2'(out_idx_q + 2'd1);
                        outbyte_d = b_q[out_idx_d];
                        ready_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign outbyte = outbyte_q;
    assign ready   = ready_q;

endmodule
